// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU selects, FSM states,
// and the canonical "no write" constants used by the MEM bundle.
package ex_stage_pkg;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_NOP  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_AND  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_MUL  = 4'd11
    } alu_sel_e;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } ex_state_e;

    localparam logic       ENABLED      = 1'b1;
    localparam logic       DISABLED     = 1'b0;
    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    // x0 is hardwired, so a write to it is never forwarded to MEM
    function automatic logic wr_en(
        input logic       we,
        input logic [4:0] rd
    );
        return (we == ENABLED) && (rd != NOP_REG_ADDR);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode -> EX -> MEM bundle: decode drives the master side,
// the execute stage sits on the slave side.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    import ex_stage_pkg::*;

    logic            in_valid;
    alu_sel_e        alusel;
    logic [XLEN-1:0] s1data;
    logic [XLEN-1:0] s2data;
    logic [4:0]      rd;
    logic            regwe;

    logic            stall_req;
    logic            out_valid;
    logic [4:0]      wd;
    logic            wreg;
    logic [XLEN-1:0] wdata;

    modport master (
        output in_valid, alusel, s1data, s2data, rd, regwe,
        input  stall_req, out_valid, wd, wreg, wdata
    );

    modport slave (
        input  in_valid, alusel, s1data, s2data, rd, regwe,
        output stall_req, out_valid, wd, wreg, wdata
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one partial product per edge.
// MUL_EARLY_EXIT_EN: finish once the remaining multiplier bits are zero.
module ex_mul_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_nxt;
    logic [CW-1:0]   count;
    logic            busy;
    logic            last;

    assign busy    = (count != '0);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign result  = acc_nxt;

`ifdef MUL_EARLY_EXIT_EN
    assign last = (count == CW'(1)) || (mplier[XLEN-1:1] == '0);
`else
    assign last = (count == CW'(1));
`endif

    assign done = busy && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CW'(MUL_CYCLES);
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= done ? '0 : count - CW'(1);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: 1-cycle ALU plus iterative MUL that stalls decode.
// MUL_EARLY_EXIT_EN shortens MUL when high multiplier bits are zero.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    ex_state_e       state;
    logic [4:0]      mrd;
    logic            mwe;
    logic [XLEN-1:0] alu_res;
    logic            alu_we;
    logic [4:0]      shamt;
    logic            accept;
    logic            start;
    logic            mdone;
    logic [XLEN-1:0] mres;

    assign accept        = bus.in_valid && (state == EX_IDLE);
    assign start         = accept && (bus.alusel == ALU_MUL);
    assign bus.stall_req = (state == EX_BUSY);
    assign shamt         = bus.s2data[4:0];

    ex_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (bus.s1data),
        .b      (bus.s2data),
        .done   (mdone),
        .result (mres)
    );

    // NOP, MUL and unknown selects produce no 1-cycle write
    always_comb begin
        alu_res = '0;
        alu_we  = DISABLED;
        case (bus.alusel)
            ALU_OR: begin
                alu_res = bus.s1data | bus.s2data;
                alu_we  = ENABLED;
            end
            ALU_AND: begin
                alu_res = bus.s1data & bus.s2data;
                alu_we  = ENABLED;
            end
            ALU_XOR: begin
                alu_res = bus.s1data ^ bus.s2data;
                alu_we  = ENABLED;
            end
            ALU_ADD: begin
                alu_res = bus.s1data + bus.s2data;
                alu_we  = ENABLED;
            end
            ALU_SUB: begin
                alu_res = bus.s1data - bus.s2data;
                alu_we  = ENABLED;
            end
            ALU_SLL: begin
                alu_res = bus.s1data << shamt;
                alu_we  = ENABLED;
            end
            ALU_SRL: begin
                alu_res = bus.s1data >> shamt;
                alu_we  = ENABLED;
            end
            ALU_SRA: begin
                alu_res = $unsigned($signed(bus.s1data) >>> shamt);
                alu_we  = ENABLED;
            end
            ALU_SLT: begin
                alu_res = {{(XLEN-1){1'b0}},
                    ($signed(bus.s1data) < $signed(bus.s2data))};
                alu_we  = ENABLED;
            end
            ALU_SLTU: begin
                alu_res = {{(XLEN-1){1'b0}},
                    (bus.s1data < bus.s2data)};
                alu_we  = ENABLED;
            end
            default: begin
                alu_res = '0;
                alu_we  = DISABLED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= EX_IDLE;
            mrd           <= NOP_REG_ADDR;
            mwe           <= DISABLED;
            bus.out_valid <= 1'b0;
            bus.wd        <= NOP_REG_ADDR;
            bus.wreg      <= DISABLED;
            bus.wdata     <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                EX_IDLE: begin
                    if (start) begin
                        state <= EX_BUSY;
                        mrd   <= bus.rd;
                        mwe   <= bus.regwe;
                    end else if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.wd        <= bus.rd;
                        bus.wreg      <= alu_we &&
                            wr_en(bus.regwe, bus.rd);
                        bus.wdata     <= alu_res;
                    end
                end
                EX_BUSY: begin
                    if (mdone) begin
                        state         <= EX_IDLE;
                        bus.out_valid <= 1'b1;
                        bus.wd        <= mrd;
                        bus.wreg      <= wr_en(mwe, mrd);
                        bus.wdata     <= mres;
                    end
                end
                default: state <= EX_IDLE;
            endcase
        end
    end

endmodule
